// File: rtl/mem_responder.sv
// Single-port word memory that serves instruction fetches and data loads/stores.
// Data port wins collisions; an optional post-reset zero-fill runs before any request is served.
module mem_responder #(
    parameter int unsigned DEPTH_LOG2     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_mem_req,
    input  logic [31:0] i_mem_addr,
    output logic [31:0] i_mem_data,
    output logic        i_mem_valid,
    input  logic [31:0] d_mem_addr,
    input  logic [31:0] d_mem_w_data,
    input  logic        d_mem_we,
    input  logic        d_mem_oe,
    output logic [31:0] d_mem_r_data,
    output logic        d_mem_valid,
    output logic        stall,
    output logic        addr_err
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned AW    = DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [CW-1:0] clr_idx;
    logic [CW-1:0] clr_idx_nxt;

    logic [31:0]   mem [DEPTH];

    logic          d_sel_c;
    logic [31:0]   acc_addr_c;
    logic [AW-1:0] acc_idx_c;
    logic          acc_in_range_c;

    logic          mem_we_c;
    logic [AW-1:0] mem_widx_c;
    logic [31:0]   mem_wdata_c;
    logic          rd_d_c;
    logic          rd_i_c;
    logic          st_c;

    logic          unused_addr_lsbs;

    // The data port owns the array whenever it requests anything
    assign d_sel_c        = d_mem_we | d_mem_oe;
    assign acc_addr_c     = d_sel_c ? d_mem_addr : i_mem_addr;
    assign acc_idx_c      = acc_addr_c[AW+1:2];
    assign acc_in_range_c = (acc_addr_c[31:AW+2] == '0);
    assign unused_addr_lsbs = ^acc_addr_c[1:0];

    assign stall = rst ? CLEAR_ON_RESET
                       : ((state == ST_CLEAR) | (i_mem_req & d_sel_c));

    // State and clear-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next state and array access selection
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        mem_we_c    = 1'b0;
        mem_widx_c  = '0;
        mem_wdata_c = '0;
        rd_d_c      = 1'b0;
        rd_i_c      = 1'b0;
        st_c        = 1'b0;
        if (state == ST_CLEAR) begin
            mem_we_c    = 1'b1;
            mem_widx_c  = clr_idx[AW-1:0];
            clr_idx_nxt = clr_idx + CW'(1);
            if (clr_idx == CW'(DEPTH - 1)) begin
                state_nxt = ST_READY;
            end
        end else begin
            if (d_mem_we) begin
                // A simultaneous load request is folded into the store
                st_c        = 1'b1;
                mem_we_c    = acc_in_range_c;
                mem_widx_c  = acc_idx_c;
                mem_wdata_c = d_mem_w_data;
            end else if (d_mem_oe) begin
                rd_d_c = 1'b1;
            end else if (i_mem_req) begin
                rd_i_c = 1'b1;
            end
        end
    end

    // Array write port; nothing is written while reset is held
    always_ff @(posedge clk) begin
        if (mem_we_c && !rst) begin
            mem[mem_widx_c] <= mem_wdata_c;
        end
    end

    // Registered read data, valid pulses and range error
    always_ff @(posedge clk) begin
        if (rst) begin
            i_mem_data   <= '0;
            i_mem_valid  <= 1'b0;
            d_mem_r_data <= '0;
            d_mem_valid  <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            i_mem_valid <= rd_i_c;
            d_mem_valid <= rd_d_c;
            addr_err    <= (st_c | rd_d_c | rd_i_c) & ~acc_in_range_c;
            if (rd_d_c) begin
                d_mem_r_data <= acc_in_range_c ? mem[acc_idx_c] : '0;
            end
            if (rd_i_c) begin
                i_mem_data <= acc_in_range_c ? mem[acc_idx_c] : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder (16-word array, clear on reset): directed vector table,
// multi-cycle reset/clear sequences and randomized traffic against a word-array model.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_mem_req = 1'b0;
    logic [31:0] i_mem_addr = '0;
    logic [31:0] i_mem_data;
    logic        i_mem_valid;
    logic [31:0] d_mem_addr = '0;
    logic [31:0] d_mem_w_data = '0;
    logic        d_mem_we = 1'b0;
    logic        d_mem_oe = 1'b0;
    logic [31:0] d_mem_r_data;
    logic        d_mem_valid;
    logic        stall;
    logic        addr_err;

    int total = 0;
    int bad   = 0;

    mem_responder #(.DEPTH_LOG2(4), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mem_req    (i_mem_req),
        .i_mem_addr   (i_mem_addr),
        .i_mem_data   (i_mem_data),
        .i_mem_valid  (i_mem_valid),
        .d_mem_addr   (d_mem_addr),
        .d_mem_w_data (d_mem_w_data),
        .d_mem_we     (d_mem_we),
        .d_mem_oe     (d_mem_oe),
        .d_mem_r_data (d_mem_r_data),
        .d_mem_valid  (d_mem_valid),
        .stall        (stall),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ireq;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic        we;
        logic        oe;
        logic        ex_stall;
        logic        ex_iv;
        logic        ex_dv;
        logic        ex_err;
        logic [31:0] ex_id;
        logic [31:0] ex_dd;
    } vec_t;

    vec_t vecs[14];

    function automatic vec_t mk(input logic ireq, input logic [31:0] ia, input logic [31:0] da,
                                input logic [31:0] wd, input logic we, input logic oe,
                                input logic ex_stall, input logic ex_iv, input logic ex_dv,
                                input logic ex_err, input logic [31:0] ex_id, input logic [31:0] ex_dd);
        vec_t v;
        v.ireq = ireq; v.ia = ia; v.da = da; v.wd = wd; v.we = we; v.oe = oe;
        v.ex_stall = ex_stall; v.ex_iv = ex_iv; v.ex_dv = ex_dv; v.ex_err = ex_err;
        v.ex_id = ex_id; v.ex_dd = ex_dd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ireq, input logic [31:0] ia, input logic [31:0] da,
                         input logic [31:0] wd, input logic we, input logic oe);
        i_mem_req    = ireq;
        i_mem_addr   = ia;
        d_mem_addr   = da;
        d_mem_w_data = wd;
        d_mem_we     = we;
        d_mem_oe     = oe;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cycles with stall high after rst is released, bounded
    task automatic count_stall(output int cnt);
        cnt = 0;
        while (stall && cnt < 40) begin
            cnt++;
            tick();
        end
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 23)) * 4 + 32'($urandom_range(0, 3));
        if ($urandom_range(0, 15) == 0) a = a | 32'h0001_0000;
        return a;
    endfunction

    logic [31:0] mdl [16];

    initial begin
        int cnt;
        logic [31:0] ex_id;
        logic [31:0] ex_dd;

        vecs[0]  = mk(0, 0,     32'h08, 32'hDEADBEEF, 1, 0,  0, 0, 0, 0, 32'h0,        32'h0);
        vecs[1]  = mk(0, 0,     32'h08, 32'h0,        0, 1,  0, 0, 1, 0, 32'h0,        32'hDEADBEEF);
        vecs[2]  = mk(0, 0,     32'h04, 32'h11111111, 1, 0,  0, 0, 0, 0, 32'h0,        32'hDEADBEEF);
        vecs[3]  = mk(1, 32'h04, 32'h08, 32'h0,       0, 1,  1, 0, 1, 0, 32'h0,        32'hDEADBEEF);
        vecs[4]  = mk(1, 32'h04, 32'h00, 32'h0,       0, 0,  0, 1, 0, 0, 32'h11111111, 32'hDEADBEEF);
        vecs[5]  = mk(0, 0,     32'h40, 32'h0,        0, 1,  0, 0, 1, 1, 32'h11111111, 32'h0);
        vecs[6]  = mk(0, 0,     32'h44, 32'hCAFEF00D, 1, 0,  0, 0, 0, 1, 32'h11111111, 32'h0);
        vecs[7]  = mk(0, 0,     32'h04, 32'h0,        0, 1,  0, 0, 1, 0, 32'h11111111, 32'h11111111);
        vecs[8]  = mk(0, 0,     32'h0C, 32'h12345678, 1, 1,  0, 0, 0, 0, 32'h11111111, 32'h11111111);
        vecs[9]  = mk(0, 0,     32'h0C, 32'h0,        0, 1,  0, 0, 1, 0, 32'h11111111, 32'h12345678);
        vecs[10] = mk(1, 32'h80, 32'h00, 32'h0,       0, 0,  0, 1, 0, 1, 32'h0,        32'h12345678);
        vecs[11] = mk(0, 0,     32'h00, 32'h0,        0, 0,  0, 0, 0, 0, 32'h0,        32'h12345678);
        vecs[12] = mk(0, 0,     32'h08, 32'h0,        0, 1,  0, 0, 1, 0, 32'h0,        32'hDEADBEEF);
        vecs[13] = mk(0, 0,     32'h0C, 32'h0,        0, 1,  0, 0, 1, 0, 32'h0,        32'h12345678);

        // Reset state
        repeat (3) tick();
        chk("rst_i_data",  i_mem_data, 32'h0);
        chk("rst_d_data",  d_mem_r_data, 32'h0);
        chk("rst_i_valid", 32'(i_mem_valid), 32'h0);
        chk("rst_d_valid", 32'(d_mem_valid), 32'h0);
        chk("rst_addr_err", 32'(addr_err), 32'h0);
        chk("rst_stall",   32'(stall), 32'h1);

        // Clear duration
        rst = 1'b0;
        count_stall(cnt);
        chk("clear_cycles", 32'(cnt), 32'd16);

        // Every word reads back zero after the clear
        for (int a = 0; a < 64; a += 4) begin
            drive(1, 32'(a), 0, 0, 0, 0);
            tick();
            chk("sweep_i_valid", 32'(i_mem_valid), 32'h1);
            chk("sweep_i_data",  i_mem_data, 32'h0);
        end
        drive(0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].ireq, vecs[i].ia, vecs[i].da, vecs[i].wd, vecs[i].we, vecs[i].oe);
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].ex_stall));
            tick();
            chk($sformatf("vec%0d_i_valid", i), 32'(i_mem_valid), 32'(vecs[i].ex_iv));
            chk($sformatf("vec%0d_d_valid", i), 32'(d_mem_valid), 32'(vecs[i].ex_dv));
            chk($sformatf("vec%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].ex_err));
            chk($sformatf("vec%0d_i_data", i), i_mem_data, vecs[i].ex_id);
            chk($sformatf("vec%0d_d_data", i), d_mem_r_data, vecs[i].ex_dd);
        end

        // Reset squashes a load issued in the same cycle
        drive(0, 0, 32'h08, 0, 0, 1);
        rst = 1'b1;
        tick();
        chk("squash_d_valid", 32'(d_mem_valid), 32'h0);
        chk("squash_d_data",  d_mem_r_data, 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("midclear_stall", 32'(stall), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_stall(cnt);
        chk("reclear_cycles", 32'(cnt), 32'd16);
        drive(0, 0, 32'h08, 0, 0, 1);
        tick();
        chk("reclear_d_valid", 32'(d_mem_valid), 32'h1);
        chk("reclear_d_data",  d_mem_r_data, 32'h0);

        // Randomized traffic against a word-array model
        for (int k = 0; k < 16; k++) mdl[k] = 32'h0;
        ex_id = 32'h0;
        ex_dd = 32'h0;
        for (int n = 0; n < 400; n++) begin
            logic ireq, we, oe, ev_i, ev_d, er, inr;
            logic [31:0] ia, da, wd, a;
            int idx;
            ireq = ($urandom_range(0, 1) == 1);
            we   = ($urandom_range(0, 3) == 0);
            oe   = ($urandom_range(0, 2) == 0);
            ia   = rand_addr();
            da   = rand_addr();
            wd   = $urandom();
            drive(ireq, ia, da, wd, we, oe);
            #1;
            chk("rnd_stall", 32'(stall), 32'(ireq & (we | oe)));
            ev_i = 0; ev_d = 0; er = 0;
            a    = (we || oe) ? da : ia;
            inr  = ((a >> 6) == 0);
            idx  = int'((a >> 2) % 16);
            if (we) begin
                if (inr) mdl[idx] = wd;
                er = !inr;
            end else if (oe) begin
                ev_d  = 1;
                ex_dd = inr ? mdl[idx] : 32'h0;
                er    = !inr;
            end else if (ireq) begin
                ev_i  = 1;
                ex_id = inr ? mdl[idx] : 32'h0;
                er    = !inr;
            end
            tick();
            chk("rnd_i_valid",  32'(i_mem_valid), 32'(ev_i));
            chk("rnd_d_valid",  32'(d_mem_valid), 32'(ev_d));
            chk("rnd_addr_err", 32'(addr_err), 32'(er));
            chk("rnd_i_data",   i_mem_data, ex_id);
            chk("rnd_d_data",   d_mem_r_data, ex_dd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
